// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: register map, STATUS/CTRL bit
// positions, FSM state encoding and the STATUS word packing helper.
package spi_slave_pkg;

  // Wishbone word addresses
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NE     = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_UNDERRUN  = 5;
  localparam int ST_ACTIVE    = 6;

  // CTRL bit positions
  localparam int CT_IE_RXNE = 0;
  localparam int CT_IE_TXE  = 1;
  localparam int CT_IE_ERR  = 2;

  // Byte shifted out when the host clocks a frame with nothing queued
  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } spi_state_e;

  // Field order matches the STATUS bit positions (rx_ne is bit 0)
  typedef struct packed {
    logic active;
    logic underrun;
    logic overrun;
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_ne;
  } status_t;

  function automatic logic [31:0] status_word(input status_t s);
    return {25'd0, s};
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Wishbone slave bus bundle for the SPI slave register block.
interface spi_slave_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/spi_slave_byte_fifo.sv
// Byte-wide synchronous FIFO. Simultaneous push and pop are accepted in
// any state with data in flight; a pop on an empty FIFO is ignored and a
// push on a full FIFO is only taken when a pop frees a slot in that cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != FULL_CNT) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with Wishbone register interface, RX/TX byte FIFOs,
// sticky error flags and a level interrupt. SPI pins are synchronized
// into clk_i; an edge takes effect on the third clk_i edge after the pin moves.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  spi_slave_if.slave   wb,
  input  logic         ss_n,
  input  logic         sclk,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  output logic         interrupt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Synchronizers, edge detector history and post-reset arming
  logic ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d, ss_prev_q, ss_prev_d;
  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
  logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  logic [1:0] hold_q, hold_d;
  logic armed_q, armed_d;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  // Transfer engine state
  spi_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic       tx_load, ovr_set, und_set;

  // Register block state
  logic        overrun_q, overrun_d, underrun_q, underrun_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        irq_q, irq_d;
  logic        wb_req, wb_rd, wb_wr;
  status_t     status;

  // FIFO hookup
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_din, rx_dout;
  logic [CW-1:0] rx_count;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;

  logic unused_bits;
  assign unused_bits = ^{wb.sel_i[3:1], wb.dat_i[31:8]};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .din_i   (rx_din),
    .pop_i   (rx_pop),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .din_i   (wb.dat_i[7:0]),
    .pop_i   (tx_pop),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // Pin synchronizers and edge detection; a falling ss_n only counts once
  // ss_n has been seen high from the pin after reset, so a select held
  // low across reset cannot restart the abandoned transfer
  always_comb begin
    ss_meta_d   = ss_n;
    ss_sync_d   = ss_meta_q;
    ss_prev_d   = ss_sync_q;
    sclk_meta_d = sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;
    hold_d      = {hold_q[0], 1'b1};
    armed_d     = armed_q | (hold_q[1] & ss_sync_q);
    ss_fall     = armed_q & ss_prev_q & ~ss_sync_q;
    ss_rise     = ~ss_prev_q & ss_sync_q;
    sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    sclk_fall   = ~sclk_sync_q & sclk_prev_q;
  end

  // Wishbone decode: side effects fire on the edge that raises ack
  always_comb begin
    wb_req  = wb.cyc_i & wb.stb_i & ~ack_q;
    wb_rd   = wb_req & ~wb.we_i;
    wb_wr   = wb_req & wb.we_i & wb.sel_i[0];
    rx_pop  = wb_rd & (wb.adr_i == ADR_DATA) & ~rx_empty;
    tx_push = wb_wr & (wb.adr_i == ADR_DATA);
    ack_d   = wb_req;
    ctrl_d  = (wb_wr && wb.adr_i == ADR_CTRL) ? wb.dat_i[2:0] : ctrl_q;

    status.active   = (state_q == S_ACTIVE);
    status.underrun = underrun_q;
    status.overrun  = overrun_q;
    status.tx_full  = tx_full;
    status.tx_empty = (tx_count == '0);
    status.rx_full  = rx_full;
    status.rx_ne    = (rx_count != '0);

    dat_o_d = 32'd0;
    if (wb_rd) begin
      case (wb.adr_i)
        ADR_DATA:   dat_o_d = rx_empty ? 32'd0 : {24'd0, rx_dout};
        ADR_STATUS: dat_o_d = status_word(status);
        ADR_CTRL:   dat_o_d = {29'd0, ctrl_q};
        default:    dat_o_d = 32'd0;
      endcase
    end
  end

  // Transfer engine next-state: frame start/abort, bit shifting, byte hand-off
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_sh_d  = rx_sh_q;
    tx_sh_d  = tx_sh_q;
    rx_push  = 1'b0;
    rx_din   = {rx_sh_q[6:0], mosi_sync_q};
    tx_load  = 1'b0;
    tx_pop   = 1'b0;
    ovr_set  = 1'b0;
    und_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d  = S_ACTIVE;
          bitcnt_d = 3'd0;
          tx_load  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          state_d  = S_IDLE;
          bitcnt_d = 3'd0;
        end else if (sclk_rise) begin
          rx_sh_d  = rx_din;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            rx_push = 1'b1;
            ovr_set = rx_full & ~rx_pop;
          end
        end else if (sclk_fall) begin
          // Counter back at zero on a falling edge means a byte just completed
          if (bitcnt_q == 3'd0) tx_load = 1'b1;
          else                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tx_load) begin
      if (!tx_empty) begin
        tx_pop  = 1'b1;
        tx_sh_d = tx_dout;
      end else begin
        tx_sh_d = TX_IDLE_BYTE;
        und_set = 1'b1;
      end
    end

    // A new error event in the same cycle as a W1C keeps the flag set
    overrun_d  = ovr_set | (overrun_q & ~(wb_wr && wb.adr_i == ADR_STATUS && wb.dat_i[ST_OVERRUN]));
    underrun_d = und_set | (underrun_q & ~(wb_wr && wb.adr_i == ADR_STATUS && wb.dat_i[ST_UNDERRUN]));

    miso_oe_d = (state_d == S_ACTIVE);
    miso_d    = (state_d == S_ACTIVE) ? tx_sh_d[7] : 1'b0;

    irq_d = (status.rx_ne & ctrl_q[CT_IE_RXNE])
          | (status.tx_empty & ctrl_q[CT_IE_TXE])
          | ((overrun_q | underrun_q) & ctrl_q[CT_IE_ERR]);
  end

  // All state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      hold_q      <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      rx_sh_q     <= 8'd0;
      tx_sh_q     <= 8'd0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      ctrl_q      <= 3'd0;
      ack_q       <= 1'b0;
      dat_o_q     <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      ss_prev_q   <= ss_prev_d;
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      hold_q      <= hold_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      ctrl_q      <= ctrl_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
      irq_q       <= irq_d;
    end
  end

  assign wb.ack_o  = ack_q;
  assign wb.dat_o  = dat_o_q;
  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: Wishbone host tasks, an SPI mode-0
// master at clk_i/8, and one task per scenario with inline checks.
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  logic ss_n, sclk, mosi;
  logic miso, miso_oe, interrupt;
  int   tests = 0;
  int   fails = 0;

  spi_slave_if bus ();

  spi_slave #(.FIFO_DEPTH(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .wb        (bus.slave),
    .ss_n      (ss_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    bit got = 0;
    @(posedge clk); #1;
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = a; bus.dat_i = d; bus.sel_i = 4'hF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) got = 1;
    end
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    tests++;
    if (!got) begin fails++; $display("FAIL wb_write_ack adr=%0d got no ack, required ack", a); end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    bit got = 0;
    d = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = a; bus.sel_i = 4'hF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) begin got = 1; d = bus.dat_o; end
    end
    bus.cyc_i = 0; bus.stb_i = 0;
    tests++;
    if (!got) begin fails++; $display("FAIL wb_read_ack adr=%0d got no ack, required ack", a); end
  endtask

  task automatic spi_select();
    ss_n = 0; repeat (6) @(posedge clk); #1;
  endtask

  task automatic spi_deselect();
    ss_n = 1; repeat (6) @(posedge clk); #1;
  endtask

  // Clock nbits bits of mo (MSB first); miso sampled just before each rising edge
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      repeat (4) @(posedge clk); #1;
      mi[i] = miso;
      sclk = 1;
      repeat (4) @(posedge clk); #1;
      sclk = 0;
    end
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i = 0; ss_n = 1; sclk = 0; mosi = 0;
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = 0; bus.sel_i = 0; bus.dat_i = 0;
    repeat (3) @(posedge clk); #1;
    tests++;
    if ({bus.ack_o, bus.dat_o, miso, miso_oe, interrupt} !== 36'd0) begin
      fails++; $display("FAIL reset_outputs got ack=%b dat=%h miso=%b oe=%b irq=%b, required all 0",
                        bus.ack_o, bus.dat_o, miso, miso_oe, interrupt);
    end
    rst_i = 1;
    repeat (2) @(posedge clk); #1;
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h04) begin fails++; $display("FAIL reset_status got %h, required 00000004", d); end
    wb_read(ADR_CTRL, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h, required 00000000", d); end
    wb_read(2'd3, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reserved_read got %h, required 00000000", d); end
  endtask

  task automatic test_basic_xfer();
    logic [31:0] d;
    logic [7:0]  mi;
    wb_write(ADR_DATA, 32'hA5);
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h00) begin fails++; $display("FAIL basic_status_pre got %h, required 00000000", d); end
    spi_select();
    tests++;
    if (miso_oe !== 1'b1) begin fails++; $display("FAIL basic_miso_oe got %b, required 1", miso_oe); end
    spi_bits(8'h3C, 8, mi);
    spi_deselect();
    tests++;
    if (mi !== 8'hA5) begin fails++; $display("FAIL basic_miso got %h, required a5", mi); end
    tests++;
    if (miso_oe !== 1'b0) begin fails++; $display("FAIL basic_oe_idle got %b, required 0", miso_oe); end
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h25) begin fails++; $display("FAIL basic_status_post got %h, required 00000025", d); end
    wb_read(ADR_DATA, d);
    tests++;
    if (d !== 32'h3C) begin fails++; $display("FAIL basic_data got %h, required 0000003c", d); end
    wb_read(ADR_STATUS, d);
    tests++;
    if (d[ST_RX_NE] !== 1'b0) begin fails++; $display("FAIL basic_rxne_after got %b, required 0", d[ST_RX_NE]); end
    wb_write(ADR_STATUS, 32'h20);
  endtask

  task automatic test_underrun();
    logic [31:0] d;
    logic [7:0]  mi;
    wb_write(ADR_CTRL, 32'h4);
    repeat (2) @(posedge clk); #1;
    tests++;
    if (interrupt !== 1'b0) begin fails++; $display("FAIL underrun_irq_pre got %b, required 0", interrupt); end
    spi_select();
    spi_bits(8'h00, 8, mi);
    spi_deselect();
    tests++;
    if (mi !== 8'hFF) begin fails++; $display("FAIL underrun_miso got %h, required ff", mi); end
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h25) begin fails++; $display("FAIL underrun_status got %h, required 00000025", d); end
    tests++;
    if (interrupt !== 1'b1) begin fails++; $display("FAIL underrun_irq got %b, required 1", interrupt); end
    wb_write(ADR_STATUS, 32'h20);
    repeat (2) @(posedge clk); #1;
    tests++;
    if (interrupt !== 1'b0) begin fails++; $display("FAIL underrun_irq_clr got %b, required 0", interrupt); end
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h05) begin fails++; $display("FAIL underrun_status_clr got %h, required 00000005", d); end
    wb_read(ADR_DATA, d);
    tests++;
    if (d !== 32'h00) begin fails++; $display("FAIL underrun_data got %h, required 00000000", d); end
    wb_write(ADR_CTRL, 32'h0);
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [7:0]  mi;
    logic [31:0] exp_rd [5] = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h00};
    spi_select();
    for (int b = 1; b <= 5; b++) spi_bits(8'(b), 8, mi);
    spi_deselect();
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h37) begin fails++; $display("FAIL overrun_status got %h, required 00000037", d); end
    for (int k = 0; k < 5; k++) begin
      wb_read(ADR_DATA, d);
      tests++;
      if (d !== exp_rd[k]) begin fails++; $display("FAIL overrun_read%0d got %h, required %h", k, d, exp_rd[k]); end
    end
    wb_write(ADR_STATUS, 32'h30);
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h04) begin fails++; $display("FAIL overrun_status_clr got %h, required 00000004", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic [7:0]  mi;
    spi_select();
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h64) begin fails++; $display("FAIL abort_status_active got %h, required 00000064", d); end
    spi_bits(8'hFF, 5, mi);
    spi_deselect();
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h24) begin fails++; $display("FAIL abort_status got %h, required 00000024", d); end
    spi_select();
    spi_bits(8'h81, 8, mi);
    spi_deselect();
    wb_read(ADR_DATA, d);
    tests++;
    if (d !== 32'h81) begin fails++; $display("FAIL abort_next_byte got %h, required 00000081", d); end
    wb_write(ADR_STATUS, 32'h20);
  endtask

  task automatic test_reset_mid_byte();
    logic [31:0] d;
    logic [7:0]  mi;
    wb_write(ADR_DATA, 32'h5A);
    wb_write(ADR_CTRL, 32'h7);
    spi_select();
    spi_bits(8'hC0, 3, mi);
    tests++;
    if (miso_oe !== 1'b1) begin fails++; $display("FAIL rstmid_oe_pre got %b, required 1", miso_oe); end
    @(posedge clk); #1; rst_i = 0;
    @(posedge clk); #1; rst_i = 1;
    tests++;
    if ({bus.ack_o, bus.dat_o, miso, miso_oe, interrupt} !== 36'd0) begin
      fails++; $display("FAIL rstmid_outputs got ack=%b dat=%h miso=%b oe=%b irq=%b, required all 0",
                        bus.ack_o, bus.dat_o, miso, miso_oe, interrupt);
    end
    spi_bits(8'hFF, 2, mi);
    repeat (20) @(posedge clk); #1;
    tests++;
    if ({miso_oe, miso} !== 2'b00) begin fails++; $display("FAIL rstmid_oe_hold got oe=%b miso=%b, required 0 0", miso_oe, miso); end
    spi_deselect();
    spi_select();
    tests++;
    if ({miso_oe, miso} !== 2'b11) begin fails++; $display("FAIL rstmid_oe_resume got oe=%b miso=%b, required 1 1", miso_oe, miso); end
    spi_bits(8'h00, 8, mi);
    spi_deselect();
    tests++;
    if (mi !== 8'hFF) begin fails++; $display("FAIL rstmid_miso got %h, required ff", mi); end
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h25) begin fails++; $display("FAIL rstmid_status got %h, required 00000025", d); end
    wb_read(ADR_DATA, d);
    wb_write(ADR_STATUS, 32'h20);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  mi;
    logic [7:0]  mo   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  txb  [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int k = 0; k < 5; k++) wb_write(ADR_DATA, 32'hC1 + k);
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h08) begin fails++; $display("FAIL b2b_tx_full got %h, required 00000008", d); end
    spi_select();
    for (int k = 0; k < 4; k++) begin
      spi_bits(mo[k], 8, mi);
      tests++;
      if (mi !== txb[k]) begin fails++; $display("FAIL b2b_miso%0d got %h, required %h", k, mi, txb[k]); end
    end
    spi_deselect();
    wb_read(ADR_STATUS, d);
    tests++;
    if (d !== 32'h27) begin fails++; $display("FAIL b2b_status got %h, required 00000027", d); end
    @(posedge clk); #1;
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = ADR_DATA;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.ack_o !== ((k % 2) == 0)) begin
        fails++; $display("FAIL b2b_ack%0d got %b, required %b", k, bus.ack_o, (k % 2) == 0);
      end else if (bus.ack_o && bus.dat_o !== {24'd0, mo[k/2]}) begin
        fails++; $display("FAIL b2b_data%0d got %h, required %h", k / 2, bus.dat_o, mo[k/2]);
      end
    end
    bus.cyc_i = 0; bus.stb_i = 0;
    wb_read(ADR_STATUS, d);
    tests++;
    if (d[ST_RX_NE] !== 1'b0) begin fails++; $display("FAIL b2b_rxne_after got %b, required 0", d[ST_RX_NE]); end
  endtask

  initial begin
    test_reset();
    test_basic_xfer();
    test_underrun();
    test_overrun();
    test_abort();
    test_reset_mid_byte();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
